// File: rtl/xor_stream_decoder.sv
// xor_stream_decoder: recovers the original operand from an XOR mixer stream
// (data = y ^ key), tags it with a sequence number and queues it in a small
// first-word-fall-through FIFO.
// Latency: in_valid at edge N appears at the head (out_valid=1) after edge N
// when the FIFO was empty; there is no combinational path from in_* to out_*.
// Backpressure: upstream cannot be stalled; a word that finds the FIFO full
// (and no pop in the same cycle) is dropped and the sticky overflow flag is set.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   key_load, key_in    capture a new key (takes effect the cycle after load)
//   in_valid, in_y      mixed word strobe and value from the mixer
//   out_valid/out_ready head handshake; out_data/out_seq hold the head
//   level               FIFO occupancy (0..DEPTH)
//   overflow, clr_ovf   sticky drop flag and its synchronous clear
//   drop_cnt            saturating drop counter, present only when the
//                       macro XDEC_DROP_CNT_EN is defined
module xor_stream_decoder #(
  parameter int W     = 12,
  parameter int DEPTH = 4,   // power of 2, >= 2
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_load,
  input  logic [W-1:0]               key_in,
  input  logic                       in_valid,
  input  logic [W-1:0]               in_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [CNT_W-1:0]           out_seq,
  output logic [$clog2(DEPTH):0]     level,
`ifdef XDEC_DROP_CNT_EN
  output logic [15:0]                drop_cnt,
`endif
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [CNT_W-1:0] seq;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [W-1:0]     key_q;
  logic [CNT_W-1:0] seq_q;
  entry_t           head_q;
  logic             ovf_q;

  logic [LW-1:0]    level_w;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [AW:0]      wr_next;
  logic [AW:0]      rd_next;
  logic [LW-1:0]    level_next;
  entry_t           new_entry;
  entry_t           head_next;

  // Occupancy is the pointer difference; the extra MSB separates full from empty.
  assign level_w = wr_ptr - rd_ptr;
  assign empty   = (level_w == '0);
  assign full    = (level_w == LW'(DEPTH));

  assign pop  = !empty && out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && !push;

  assign wr_next    = wr_ptr + {{AW{1'b0}}, push};
  assign rd_next    = rd_ptr + {{AW{1'b0}}, pop};
  assign level_next = wr_next - rd_next;

  // Decode uses the key held before this edge, so a simultaneous key_load
  // only affects later words.
  assign new_entry.data = in_y ^ key_q;
  assign new_entry.seq  = seq_q;

  // The head register is refilled from the slot rd_next will point at. That
  // slot can only coincide with the slot being written when the FIFO drains
  // to zero before this push, in which case the incoming word becomes head.
  always_comb begin
    head_next = mem[rd_next[AW-1:0]];
    if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
      head_next = new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      key_q  <= '0;
      seq_q  <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= new_entry;
      end
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;

      // Every strobe advances the tag, dropped or not, so gaps reveal loss.
      if (in_valid) begin
        seq_q <= seq_q + 1'b1;
      end

      if (key_load) begin
        key_q <= key_in;
      end

      // Head holds its last value while the FIFO is empty.
      if (level_next != '0) begin
        head_q <= head_next;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef XDEC_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (clr_ovf) begin
      // The clear and a coincident drop leave exactly that one drop counted.
      drop_cnt_q <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_valid = !empty;
  assign out_data  = head_q.data;
  assign out_seq   = head_q.seq;
  assign level     = level_w;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_xor_stream_decoder.sv
// Bench for xor_stream_decoder: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_xor_stream_decoder;

  localparam int W     = 12;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_load = 1'b0;
  logic [W-1:0]     key_in = '0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_y = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_seq;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             clr_ovf = 1'b0;
`ifdef XDEC_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  always #5 clk = ~clk;

  xor_stream_decoder #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .level     (level),
`ifdef XDEC_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  // Reference model: a queue of {data, seq}, plus key, tag, flag and counter.
  typedef struct packed {
    logic [W-1:0]     d;
    logic [CNT_W-1:0] s;
  } ent_t;

  ent_t       q[$];
  ent_t       m_last;
  logic [W-1:0] m_key;
  int         m_seq;
  bit         m_ovf;
  int         m_drop;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = '0;
    m_key  = '0;
    m_seq  = 0;
    m_ovf  = 0;
    m_drop = 0;
  endtask

  // Apply one clock edge's worth of the rules to the model using the
  // currently driven inputs.
  task automatic model_step();
    bit pop;
    bit acc;
    bit drp;
    ent_t e;
    pop = (q.size() > 0) && out_ready;
    if (pop) void'(q.pop_front());
    acc = in_valid && (q.size() < DEPTH);
    drp = in_valid && !acc;
    if (in_valid) begin
      if (acc) begin
        e.d = in_y ^ m_key;
        e.s = m_seq[CNT_W-1:0];
        q.push_back(e);
      end
      m_seq = (m_seq + 1) % (1 << CNT_W);
    end
    if (drp) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    if (clr_ovf) m_drop = drp ? 1 : 0;
    else if (drp && m_drop < 65535) m_drop++;
    if (key_load) m_key = key_in;
    if (q.size() > 0) m_last = q[0];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".level"},     32'(level),     32'(q.size()));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".out_data"},  32'(out_data),  32'(m_last.d));
    chk({tag, ".out_seq"},   32'(out_seq),   32'(m_last.s));
`ifdef XDEC_DROP_CNT_EN
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(m_drop));
`endif
  endtask

  // Called at a falling edge: drive, step the model, clock, check.
  task automatic cycle(input string tag, input bit kl, input logic [W-1:0] ki,
                       input bit iv, input logic [W-1:0] iy, input bit ordy,
                       input bit clr);
    key_load  = kl;
    key_in    = ki;
    in_valid  = iv;
    in_y      = iy;
    out_ready = ordy;
    clr_ovf   = clr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    key_load = 0; in_valid = 0; out_ready = 0; clr_ovf = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int wraps;
  bit have_prev;
  logic [CNT_W-1:0] prev_seq;

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Load key, decode one word, pop it.
    cycle("load_a5a", 1, 12'hA5A, 0, '0, 1, 0);
    cycle("dec_fff", 0, '0, 1, 12'hFFF, 1, 0);
    chk("t1.valid", 32'(out_valid), 1);
    chk("t1.data", 32'(out_data), 32'h5A5);
    chk("t1.seq", 32'(out_seq), 0);
    cycle("pop1", 0, '0, 0, '0, 1, 0);
    chk("t1.level", 32'(level), 0);

    // Key load coincident with a word: old key applies.
    cycle("key0", 1, 12'h000, 0, '0, 0, 0);
    cycle("kl_same", 1, 12'h00F, 1, 12'h0F0, 0, 0);
    chk("t2.old_key", 32'(out_data), 32'h0F0);
    cycle("kl_next", 0, '0, 1, 12'h0F0, 1, 0);
    chk("t2.new_key", 32'(out_data), 32'h0FF);
    cycle("drain2", 0, '0, 0, '0, 1, 0);

    // Overflow: six words into a four-deep FIFO, then drain.
    do_reset("rst2");
    for (int i = 1; i <= 6; i++) cycle("fill", 0, '0, 1, W'(i), 0, 0);
    chk("t3.level", 32'(level), DEPTH);
    chk("t3.ovf", 32'(overflow), 1);
`ifdef XDEC_DROP_CNT_EN
    chk("t3.drop_cnt", 32'(drop_cnt), 2);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("t3.drain_data", 32'(out_data), 32'(i + 1));
      chk("t3.drain_seq", 32'(out_seq), 32'(i));
      cycle("drain3", 0, '0, 0, '0, 1, 0);
    end
    cycle("after_gap", 0, '0, 1, 12'h007, 0, 0);
    chk("t3.gap_seq", 32'(out_seq), 6);

    // Clear alone, then full + pop + push, then clear with a drop.
    cycle("clr", 0, '0, 0, '0, 0, 1);
    chk("t5.clr", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) cycle("fill4", 0, '0, 1, W'(8 + i), 0, 0);
    chk("t4.full", 32'(level), DEPTH);
    cycle("full_pp", 0, '0, 1, 12'h0AA, 1, 0);
    chk("t4.level", 32'(level), DEPTH);
    chk("t4.ovf", 32'(overflow), 0);
    cycle("clr_drop", 0, '0, 1, 12'h0BB, 0, 1);
    chk("t5.set_wins", 32'(overflow), 1);
    for (int i = 0; i < 5; i++) cycle("drain5", 0, '0, 0, '0, 1, 0);

    // Long stream: tag wraps 255 -> 0.
    wraps = 0;
    have_prev = 0;
    prev_seq = '0;
    for (int i = 0; i < 300; i++) begin
      cycle("stream", (i == 0), 12'h3C3, 1, W'($urandom), 1, 0);
      if (out_valid) begin
        if (have_prev && prev_seq == 8'd255) begin
          chk("t6.wrap", 32'(out_seq), 0);
          wraps++;
        end
        prev_seq = out_seq;
        have_prev = 1;
      end
    end
    chk("t6.wrap_seen", 32'(wraps > 0), 1);

    // Mid-stream reset with three words queued.
    cycle("drain6", 0, '0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) cycle("fill6", 0, '0, 1, W'(i), 0, 0);
    chk("t6.level3", 32'(level), 3);
    do_reset("rst_mid");
    chk("t6.rst_level", 32'(level), 0);
    chk("t6.rst_valid", 32'(out_valid), 0);
    cycle("post_rst", 0, '0, 1, 12'h123, 0, 0);
    chk("t6.post_data", 32'(out_data), 32'h123);
    chk("t6.post_seq", 32'(out_seq), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand",
            ($urandom_range(0, 15) == 0), W'($urandom),
            ($urandom_range(0, 99) < 55), W'($urandom),
            ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 31) == 0));
      if ((i % 1000) == 999) do_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_stream_decoder.md
Name: xor_stream_decoder

Overview:
- Receive-side counterpart of the team's XOR mixing stage.
- Consumes the mixer's valid/y result stream and recovers the original operand: data = y ^ key, using a locally loaded key.
- Decoded words are tagged with a sequence number and buffered in a small FIFO. They are presented downstream on a valid/ready handshake.
- The upstream stream has no backpressure, so overflow is flagged rather than stalled.

Parameters:
- W, 12: data and key width.
- DEPTH, 4: FIFO entries. Must be a power of 2, at least 2.
- CNT_W, 8: sequence tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- key_load  in  1  capture key_in into the key register.
- key_in  in  W  new key value.
- in_valid  in  1  upstream result strobe (driven by the mixer's valid).
- in_y  in  W  upstream mixed word (driven by the mixer's y).
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  W  decoded word at the FIFO head.
- out_seq  out  CNT_W  sequence tag of the head.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a word was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs are registered or decoded from registered state only.

Behaviour:
- Reset state: key=0, seq counter=0, FIFO empty, out_valid=0, out_data=0, out_seq=0, level=0, overflow=0.
- Key register
  - key_load=1 captures key_in at the clock edge.
  - If key_load and in_valid are high in the same cycle, the word is decoded with the OLD key; the new key applies from the next cycle.
- Decode
  - On in_valid, push {in_y ^ key, seq} into the FIFO.
  - The FIFO is purely sequential; there is no combinational path from in_* to out_*.
- Sequence counter
  - Increments by 1 on every in_valid cycle, including dropped words, so gaps in out_seq expose loss.
  - Wraps modulo 2^CNT_W.
- Latency
  - in_valid at edge N gives out_valid=1 after edge N, provided the FIFO was empty.
  - The FIFO is first-word-fall-through: out_data/out_seq hold the head whenever out_valid=1.
- Pop
  - Occurs when out_valid && out_ready.
  - out_data and out_seq must hold stable while out_valid=1 and out_ready=0.
- Push
  - Accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle. Level is unchanged in that case.
  - Otherwise the word is dropped and overflow is set.
- Simultaneous push and pop at a non-full, non-empty level: level is unchanged and the pointers both advance.
- Push into an empty FIFO with out_ready=1: the word is not bypassed. It appears at the head next cycle.
- Pointers wrap modulo DEPTH. level = write count minus read count, tracked with an extra MSB.
- overflow
  - Set by any drop.
  - clr_ovf clears it. If clr_ovf and a drop occur in the same cycle, set wins.
- When empty, out_data/out_seq hold their last value and out_valid=0. out_ready while empty has no effect.
- Reset mid-operation flushes the FIFO, zeroes the key and sequence counter, and clears overflow. No partial state survives.

Optional Feature:
- Macro: XDEC_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [15:0].
  - Counts dropped words and saturates at 16'hFFFF.
  - clr_ovf clears it. If a drop occurs in the same cycle as clr_ovf, the result is 1.
  - Reset value is 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, key_load with key_in=12'hA5A, then in_valid with in_y=12'hFFF, out_ready=1 -> next cycle out_valid=1, out_data=12'h5A5, out_seq=0; level returns to 0 after the pop.
- key_load with key_in=12'h00F in the same cycle as in_valid with in_y=12'h0F0 (old key=0) -> out_data=12'h0F0. A following in_valid with in_y=12'h0F0 -> out_data=12'h0FF.
- out_ready=0, 6 consecutive in_valid with key=0 and in_y=1..6 (DEPTH=4) -> level=4, overflow=1, drop_cnt=2 (if enabled). Drain gives data 1,2,3,4 with seq 0,1,2,3. The next accepted word carries seq 6.
- FIFO full with out_ready=1 and in_valid on the same cycle -> push accepted, level stays 4, overflow stays 0.
- clr_ovf asserted alone -> overflow=0. clr_ovf plus a drop in the same cycle -> overflow=1.
- 300 words streamed with out_ready=1 (CNT_W=8) -> out_seq wraps 255 to 0. Assert rst_n=0 mid-stream with level=3 -> level=0, out_valid=0, and the next word carries seq 0 decoded with key=0.
